axi_bus_arb: RTL and testbench
==============================

AXI_BUS_ARB -- requirements
Module: axi_bus_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: cycles a granted owner may hold the bus without done before a forced release (ARB_TIMEOUT_EN only); legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the timeout counter; SHALL satisfy 2^CNT_W >= TIMEOUT_CYCLES.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req_i  input  1  instruction-fetch (pc_reg path) requests the AXI bus.
REQ-006 if_done_i  input  1  last beat of the IF transaction, single-cycle pulse.
REQ-007 lsu_req_i  input  1  vlsu requests the AXI bus.
REQ-008 lsu_done_i  input  1  last beat of the vlsu transaction, single-cycle pulse.
REQ-009 if_gnt_o  output  1  IF owns the bus.
REQ-010 lsu_gnt_o  output  1  vlsu owns the bus.
REQ-011 bus_sel_o  output  1  AXI mux select: 0 = IF, 1 = vlsu; holds its last value when idle.
REQ-012 hold_axi_req_o  output  1  to ctrl: IF is stalled waiting for the bus.
REQ-013 timeout_o  output  1  one-cycle pulse on forced release.
REQ-014 timeout_src_o  output  1  owner that was force-released: 0 = IF, 1 = vlsu.

Function
REQ-015 FSM states: IDLE, OWN_IF, OWN_LSU; if_gnt_o = (state==OWN_IF) and lsu_gnt_o = (state==OWN_LSU), both registered-state decodes, never high together.
REQ-016 IDLE transitions: single requester -> its OWN state next cycle; both requesting -> owner opposite to last_owner; no request -> stay IDLE.
REQ-017 Grant latency: req sampled high in cycle N while IDLE -> gnt high in cycle N+1.
REQ-018 Grant is transaction-locked: once owned, the grant holds until the owner's done pulse regardless of its req level.
REQ-019 Done in cycle M: if the other requester's req is high in M, ownership passes directly to it in M+1 (no idle cycle); otherwise IDLE in M+1.
REQ-020 On done, last_owner updates to the releasing owner; this gives round-robin between the two requesters under contention.
REQ-021 The done pulse of a non-owner SHALL be ignored, with no state change.
REQ-022 hold_axi_req_o = if_req_i AND NOT if_gnt_o (combinational).
REQ-023 bus_sel_o is registered and updates in the same cycle a new grant becomes visible.

Reset
REQ-024 On rst: state=IDLE, if_gnt_o=0, lsu_gnt_o=0, bus_sel_o=0, timeout_o=0, timeout_src_o=0, counter=0, last_owner=vlsu (IF wins the first tie).
REQ-025 Reset asserted mid-transaction SHALL drop grants immediately (asynchronously); the first post-reset grant follows REQ-016/017.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN.
- Defined: the counter clears on each new grant and increments every owned cycle. If it reaches TIMEOUT_CYCLES-1 with no done, the arbiter treats that cycle as a done: release and hand-off per REQ-019, timeout_o pulses one cycle, timeout_src_o latches the owner.
- Undefined: no counter is implemented, timeout_o and timeout_src_o are tied 0, and ownership ends only on done.

Verification
REQ-027 if_req=1 alone from cycle 0 -> if_gnt=1 at cycle 1, bus_sel=0, hold_axi_req=1 at cycle 0 only.
REQ-028 if_req and lsu_req both high from reset -> IF granted first; if_done at cycle 5 -> lsu_gnt=1 at cycle 6 with no gap; lsu_done at cycle 9 with if_req still high -> if_gnt=1 at cycle 10.
REQ-029 lsu owns; lsu_req drops at cycle 3, if_done pulses at cycle 4 -> lsu_gnt stays 1 and if_done is ignored; lsu_done at cycle 7 -> IDLE at cycle 8.
REQ-030 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, lsu granted at cycle 1 with no done -> lsu_gnt falls at cycle 9, timeout_o=1 at cycle 9 only, timeout_src_o=1; without the macro lsu_gnt stays 1 indefinitely.
REQ-031 rst pulse at cycle 4 while OWN_LSU -> all outputs 0 during reset; after release with both reqs high -> IF granted first.

Source files
------------

// File: rtl/axi_bus_arb_if.sv
// Signal bundle between the AXI bus arbiter and its two requesters
// (instruction fetch and vector LSU).
//
// Handshake: a requester holds *_req_i high while it wants the bus. The
// arbiter answers with a registered *_gnt_o. Once granted, the owner keeps
// the bus until it pulses *_done_i for one cycle on its last beat. The level
// of *_req_i does not matter while the bus is owned.
//
// state_dbg_o exposes the arbiter FSM state (0 = IDLE, 1 = OWN_IF,
// 2 = OWN_LSU) for observation.
interface axi_bus_arb_if;
    logic       if_req_i;
    logic       if_done_i;
    logic       lsu_req_i;
    logic       lsu_done_i;
    logic       if_gnt_o;
    logic       lsu_gnt_o;
    logic       bus_sel_o;
    logic       hold_axi_req_o;
    logic       timeout_o;
    logic       timeout_src_o;
    logic [1:0] state_dbg_o;

    // Arbiter side
    modport slave (
        input  if_req_i,
        input  if_done_i,
        input  lsu_req_i,
        input  lsu_done_i,
        output if_gnt_o,
        output lsu_gnt_o,
        output bus_sel_o,
        output hold_axi_req_o,
        output timeout_o,
        output timeout_src_o,
        output state_dbg_o
    );

    // Requester / environment side
    modport master (
        output if_req_i,
        output if_done_i,
        output lsu_req_i,
        output lsu_done_i,
        input  if_gnt_o,
        input  lsu_gnt_o,
        input  bus_sel_o,
        input  hold_axi_req_o,
        input  timeout_o,
        input  timeout_src_o,
        input  state_dbg_o
    );
endinterface

// File: rtl/axi_bus_arb.sv
// Two-way, transaction-locked AXI bus arbiter between instruction fetch (IF)
// and the vector LSU. Ties are broken round-robin against the last releasing
// owner; the owner releases on its done pulse and the other requester, if
// waiting, takes over in the very next cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to force-release an owner that
// holds the bus for TIMEOUT_CYCLES cycles without signalling done. Without
// the macro there is no counter and timeout_o / timeout_src_o are tied 0.
module axi_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic          clk,
    input  logic          rst,
    axi_bus_arb_if.slave  bus
);

    // Parameter sanity, caught at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("axi_bus_arb: TIMEOUT_CYCLES out of range 2..65535");
    end
    if (CNT_W < 1 || CNT_W > 62 || (64'd1 << CNT_W) < 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
        $error("axi_bus_arb: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_IF  = 2'd1,
        OWN_LSU = 2'd2
    } state_e;

    // Owner encoding shared by last_owner, bus_sel and timeout_src.
    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   bus_sel_q, bus_sel_d;
    logic   expire;        // owner has used up its hold budget this cycle
    logic   release_if;    // IF gives up the bus this cycle
    logic   release_lsu;   // vlsu gives up the bus this cycle

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             timeout_src_q, timeout_src_d;

    // The budget runs out on the owner's TIMEOUT_CYCLES-th owned cycle.
    always_comb begin
        expire = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Counter restarts on every new grant and advances each owned cycle.
    always_comb begin
        cnt_d = '0;
        if (state_d != IDLE && state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout pulse fires only when the release was forced, not on a real done.
    always_comb begin
        timeout_d     = 1'b0;
        timeout_src_d = timeout_src_q;
        if (expire && state_q == OWN_IF && !bus.if_done_i) begin
            timeout_d     = 1'b1;
            timeout_src_d = OWNER_IF;
        end else if (expire && state_q == OWN_LSU && !bus.lsu_done_i) begin
            timeout_d     = 1'b1;
            timeout_src_d = OWNER_LSU;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            timeout_src_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            timeout_src_q <= timeout_src_d;
        end
    end

    assign bus.timeout_o     = timeout_q;
    assign bus.timeout_src_o = timeout_src_q;
`else
    // Ownership ends only on done.
    always_comb begin
        expire = 1'b0;
    end

    assign bus.timeout_o     = 1'b0;
    assign bus.timeout_src_o = 1'b0;
`endif

    // An owner releases on its own done pulse (or a forced timeout); the
    // other side's done is ignored because only the owner's done is decoded.
    always_comb begin
        release_if  = (state_q == OWN_IF)  && (bus.if_done_i  || expire);
        release_lsu = (state_q == OWN_LSU) && (bus.lsu_done_i || expire);
    end

    // Next-state logic: arbitration in IDLE, hand-off on release.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req_i && bus.lsu_req_i) begin
                    // Contention: the side that did not own last goes first.
                    state_d = (last_owner_q == OWNER_LSU) ? OWN_IF : OWN_LSU;
                end else if (bus.if_req_i) begin
                    state_d = OWN_IF;
                end else if (bus.lsu_req_i) begin
                    state_d = OWN_LSU;
                end
            end
            OWN_IF: begin
                if (release_if) begin
                    last_owner_d = OWNER_IF;
                    state_d      = bus.lsu_req_i ? OWN_LSU : IDLE;
                end
            end
            OWN_LSU: begin
                if (release_lsu) begin
                    last_owner_d = OWNER_LSU;
                    state_d      = bus.if_req_i ? OWN_IF : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mux select follows the next owner so it lines up with the grant;
    // it keeps its previous value while the bus is idle.
    always_comb begin
        bus_sel_d = bus_sel_q;
        if (state_d == OWN_IF) begin
            bus_sel_d = OWNER_IF;
        end else if (state_d == OWN_LSU) begin
            bus_sel_d = OWNER_LSU;
        end
    end

    // FSM and ownership registers; IF wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_LSU;
            bus_sel_q    <= OWNER_IF;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            bus_sel_q    <= bus_sel_d;
        end
    end

    // Grants are pure decodes of the registered state, so never both high.
    assign bus.if_gnt_o       = (state_q == OWN_IF);
    assign bus.lsu_gnt_o      = (state_q == OWN_LSU);
    assign bus.bus_sel_o      = bus_sel_q;
    assign bus.hold_axi_req_o = bus.if_req_i & ~(state_q == OWN_IF);
    assign bus.state_dbg_o    = state_q;

endmodule

// File: tb/tb_axi_bus_arb.sv
// Directed bench for axi_bus_arb. Each cycle drives the inputs just after the
// rising edge, queues the expected output vector, and checks it on the
// falling edge. Vector bit order:
//   {if_gnt, lsu_gnt, bus_sel, hold_axi_req, timeout, timeout_src}
// Compile with ARB_TIMEOUT_EN defined to exercise the forced-release path.
module tb_axi_bus_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_bus_arb_if bus ();

    axi_bus_arb #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         n_asserts = 0;
    int         n_fail    = 0;

    // Pop one expectation and compare against the DUT outputs.
    task automatic check_out();
        logic [5:0] got;
        logic [5:0] e;
        string      t;
        got = {bus.if_gnt_o, bus.lsu_gnt_o, bus.bus_sel_o,
               bus.hold_axi_req_o, bus.timeout_o, bus.timeout_src_o};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_asserts++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", t, got, e);
        end
    endtask

    // One clock cycle: drive, queue expectation, check mid-cycle.
    task automatic cyc(input logic r, input logic ir, input logic idn,
                       input logic lr, input logic ldn,
                       input logic [5:0] e, input string tag);
        rst            = r;
        bus.if_req_i   = ir;
        bus.if_done_i  = idn;
        bus.lsu_req_i  = lr;
        bus.lsu_done_i = ldn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse of random length with outputs checked low throughout.
    task automatic do_reset(input string tag);
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, tag);
        end
    endtask

    initial begin
        bus.if_req_i   = 1'b0;
        bus.if_done_i  = 1'b0;
        bus.lsu_req_i  = 1'b0;
        bus.lsu_done_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset_state");

        // IF alone: one-cycle grant latency, hold only before the grant.
        cyc(0, 1, 0, 0, 0, 6'b000100, "if_only_c0");
        cyc(0, 1, 0, 0, 0, 6'b100000, "if_only_c1");
        cyc(0, 1, 1, 0, 0, 6'b100000, "if_only_done");
        cyc(0, 0, 0, 0, 0, 6'b000000, "if_only_idle");

        // Contention from reset: IF first, gap-free hand-offs both ways.
        do_reset("reset_s2");
        cyc(0, 1, 0, 1, 0, 6'b000100, "both_c0");
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 0, 1, 0, 6'b100000, $sformatf("both_if_c%0d", i));
        end
        cyc(0, 1, 1, 1, 0, 6'b100000, "both_if_done_c5");
        cyc(0, 1, 0, 1, 0, 6'b011100, "both_lsu_c6");
        cyc(0, 1, 0, 1, 0, 6'b011100, "both_lsu_c7");
        cyc(0, 1, 0, 1, 0, 6'b011100, "both_lsu_c8");
        cyc(0, 1, 0, 1, 1, 6'b011100, "both_lsu_done_c9");
        cyc(0, 1, 0, 1, 0, 6'b100000, "both_if_c10");
        cyc(0, 0, 1, 0, 0, 6'b100000, "both_if_done_c11");
        cyc(0, 0, 0, 0, 0, 6'b000000, "both_idle_c12");

        // vlsu owns; its req drops and a stray if_done is ignored.
        cyc(0, 0, 0, 1, 0, 6'b000000, "lock_c0");
        cyc(0, 0, 0, 1, 0, 6'b011000, "lock_c1");
        cyc(0, 0, 0, 1, 0, 6'b011000, "lock_c2");
        cyc(0, 0, 0, 0, 0, 6'b011000, "lock_req_drop_c3");
        cyc(0, 0, 1, 0, 0, 6'b011000, "lock_stray_done_c4");
        cyc(0, 0, 0, 0, 0, 6'b011000, "lock_c5");
        cyc(0, 0, 0, 0, 0, 6'b011000, "lock_c6");
        cyc(0, 0, 0, 0, 1, 6'b011000, "lock_done_c7");
        cyc(0, 0, 0, 0, 0, 6'b001000, "lock_idle_sel_hold_c8");
        cyc(0, 1, 0, 0, 0, 6'b001100, "lock_if_req_c9");
        cyc(0, 0, 1, 0, 0, 6'b100000, "lock_if_gnt_c10");
        cyc(0, 0, 0, 0, 1, 6'b000000, "idle_stray_lsu_done");
        cyc(0, 0, 0, 0, 0, 6'b000000, "idle_after_stray");

        // vlsu holds without done.
        do_reset("reset_s4");
        cyc(0, 0, 0, 1, 0, 6'b000000, "hold_c0");
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 1, 0, 6'b011000, $sformatf("hold_lsu_c%0d", i));
        end
`ifdef ARB_TIMEOUT_EN
        cyc(0, 0, 0, 0, 0, 6'b001011, "to_lsu_fire_c9");
        cyc(0, 1, 0, 0, 0, 6'b001101, "to_pulse_end_c10");
        for (int i = 11; i <= 16; i++) begin
            cyc(0, 1, 0, 0, 0, 6'b100001, $sformatf("to_if_c%0d", i));
        end
        cyc(0, 1, 0, 1, 0, 6'b100001, "to_if_c17");
        cyc(0, 1, 0, 1, 0, 6'b100001, "to_if_c18");
        cyc(0, 1, 0, 1, 1, 6'b011110, "to_if_fire_handoff_c19");
        cyc(0, 1, 1, 0, 0, 6'b100000, "to_back_to_if_c20");
        cyc(0, 0, 0, 0, 0, 6'b000000, "to_idle_c21");
`else
        for (int i = 9; i <= 40; i++) begin
            cyc(0, 0, 0, 1, 0, 6'b011000, $sformatf("hold_lsu_c%0d", i));
        end
        cyc(0, 0, 0, 0, 1, 6'b011000, "hold_done");
        cyc(0, 0, 0, 0, 0, 6'b001000, "hold_idle");
`endif

        // Asynchronous reset while vlsu owns, then a fresh tie goes to IF.
        do_reset("reset_s5");
        cyc(0, 0, 0, 1, 0, 6'b000000, "rst_mid_c0");
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 1, 0, 6'b011000, $sformatf("rst_mid_lsu_c%0d", i));
        end
        cyc(1, 0, 0, 1, 0, 6'b000000, "rst_mid_async_drop_c4");
        cyc(1, 0, 0, 1, 0, 6'b000000, "rst_mid_held_c5");
        cyc(0, 1, 0, 1, 0, 6'b000100, "post_rst_c0");
        cyc(0, 1, 0, 1, 0, 6'b100000, "post_rst_if_first_c1");
        cyc(0, 0, 1, 0, 0, 6'b100000, "post_rst_done_c2");
        cyc(0, 0, 0, 0, 0, 6'b000000, "post_rst_idle_c3");

        // Every queued expectation must have been consumed.
        n_asserts++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
